// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_t  - arbiter FSM state encoding
//   GRANT_IFETCH - grant index of the instruction-fetch requester (port 0)
//   GRANT_LSU    - grant index of the load/store requester (port 1)
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    localparam logic GRANT_IFETCH = 1'b0;
    localparam logic GRANT_LSU    = 1'b1;

endpackage : arb_pkg

// File: rtl/mux2.sv
// mux2: parameterised two-input multiplexer.
//   P_WIDTH - data width
//   i_sel   - 0 selects i_d0, 1 selects i_d1
//   i_d0    - input 0
//   i_d1    - input 1
//   o_y     - selected data
module mux2 #(
    parameter int P_WIDTH = 1
) (
    input  logic               i_sel,
    input  logic [P_WIDTH-1:0] i_d0,
    input  logic [P_WIDTH-1:0] i_d1,
    output logic [P_WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule : mux2

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: round-robin arbiter between the instruction-fetch requester
// (port 0) and the load/store requester (port 1) for one shared memory port.
// One transaction at a time: arbitrate, issue, wait for the completion.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_reqN_valid/addr/we/wdata   request from port N (held until ready)
//   o_reqN_ready                 request N accepted by memory this cycle
//   o_rspN_valid, o_rspN_rdata   completion pulse for port N, read data
//   o_mem_valid/addr/we/wdata    request to memory, payload of granted port
//   i_mem_ready                  memory accepts the request
//   i_mem_rsp_valid, i_mem_rdata memory completion (reads and writes)
//   o_grant                      registered grant index
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | nothing in flight; arbitrate pending requests
// ISSUE    | o_mem_valid high, payload from requester o_grant
// WAIT_RSP | request accepted, waiting for i_mem_rsp_valid
module mem_arbiter2
    import arb_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic                    i_req0_valid,
    input  logic [P_ADDR_WIDTH-1:0] i_req0_addr,
    input  logic                    i_req0_we,
    input  logic [P_DATA_WIDTH-1:0] i_req0_wdata,
    output logic                    o_req0_ready,

    input  logic                    i_req1_valid,
    input  logic [P_ADDR_WIDTH-1:0] i_req1_addr,
    input  logic                    i_req1_we,
    input  logic [P_DATA_WIDTH-1:0] i_req1_wdata,
    output logic                    o_req1_ready,

    output logic                    o_rsp0_valid,
    output logic [P_DATA_WIDTH-1:0] o_rsp0_rdata,
    output logic                    o_rsp1_valid,
    output logic [P_DATA_WIDTH-1:0] o_rsp1_rdata,

    output logic                    o_mem_valid,
    input  logic                    i_mem_ready,
    output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                    o_mem_we,
    output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                    i_mem_rsp_valid,
    input  logic [P_DATA_WIDTH-1:0] i_mem_rdata,

    output logic                    o_grant
);

    arb_state_t state, state_nxt;
    logic       grant, grant_nxt;
    logic       last_grant, last_grant_nxt;

    logic [P_ADDR_WIDTH-1:0] mux_addr;
    logic [P_DATA_WIDTH:0]   mux_we_wdata;

    // Payload steering is driven only by the registered grant, so there is
    // no path from the memory handshake inputs into the request payload.
    mux2 #(
        .P_WIDTH(P_ADDR_WIDTH)
    ) u_mux_addr (
        .i_sel (grant),
        .i_d0  (i_req0_addr),
        .i_d1  (i_req1_addr),
        .o_y   (mux_addr)
    );

    mux2 #(
        .P_WIDTH(P_DATA_WIDTH + 1)
    ) u_mux_wdata (
        .i_sel (grant),
        .i_d0  ({i_req0_we, i_req0_wdata}),
        .i_d1  ({i_req1_we, i_req1_wdata}),
        .o_y   (mux_we_wdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            grant      <= GRANT_IFETCH;
            last_grant <= GRANT_LSU;   // port 0 wins the first conflict
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;

        o_mem_valid    = 1'b0;
        o_mem_addr     = '0;
        o_mem_we       = 1'b0;
        o_mem_wdata    = '0;
        o_req0_ready   = 1'b0;
        o_req1_ready   = 1'b0;
        o_rsp0_valid   = 1'b0;
        o_rsp1_valid   = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_req0_valid && i_req1_valid) begin
                    grant_nxt = ~last_grant;
                    state_nxt = ISSUE;
                end else if (i_req0_valid) begin
                    grant_nxt = GRANT_IFETCH;
                    state_nxt = ISSUE;
                end else if (i_req1_valid) begin
                    grant_nxt = GRANT_LSU;
                    state_nxt = ISSUE;
                end
            end

            // The grant is held even if the requester drops valid here;
            // the memory port keeps seeing the request until accepted.
            ISSUE: begin
                o_mem_valid  = 1'b1;
                o_mem_addr   = mux_addr;
                o_mem_we     = mux_we_wdata[P_DATA_WIDTH];
                o_mem_wdata  = mux_we_wdata[P_DATA_WIDTH-1:0];
                o_req0_ready = i_mem_ready && (grant == GRANT_IFETCH);
                o_req1_ready = i_mem_ready && (grant == GRANT_LSU);
                if (i_mem_ready) begin
                    state_nxt = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                o_rsp0_valid = i_mem_rsp_valid && (grant == GRANT_IFETCH);
                o_rsp1_valid = i_mem_rsp_valid && (grant == GRANT_LSU);
                if (i_mem_rsp_valid) begin
                    last_grant_nxt = grant;
                    state_nxt      = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read data is broadcast; only the valid pulse identifies the owner.
    assign o_rsp0_rdata = i_mem_rdata;
    assign o_rsp1_rdata = i_mem_rdata;

    assign o_grant = grant;

endmodule : mem_arbiter2

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: directed bench for mem_arbiter2 with a transaction-level
// reference model checked every cycle plus hand-computed expectations.
module tb_mem_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 0, req1_valid = 0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic          req0_we = 0, req1_we = 0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_ready, req1_ready;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_valid;
    logic          mem_ready = 0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_rsp_valid = 0;
    logic [DW-1:0] mem_rdata = '0;
    logic          grant;

    int n_cmp  = 0;
    int n_fail = 0;

    int cnt_rdy0 = 0, cnt_rdy1 = 0, cnt_rsp0 = 0, cnt_rsp1 = 0;
    int order_q[$];

    always #5 clk = ~clk;

    mem_arbiter2 #(
        .P_ADDR_WIDTH(AW),
        .P_DATA_WIDTH(DW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req0_valid    (req0_valid),
        .i_req0_addr     (req0_addr),
        .i_req0_we       (req0_we),
        .i_req0_wdata    (req0_wdata),
        .o_req0_ready    (req0_ready),
        .i_req1_valid    (req1_valid),
        .i_req1_addr     (req1_addr),
        .i_req1_we       (req1_we),
        .i_req1_wdata    (req1_wdata),
        .o_req1_ready    (req1_ready),
        .o_rsp0_valid    (rsp0_valid),
        .o_rsp0_rdata    (rsp0_rdata),
        .o_rsp1_valid    (rsp1_valid),
        .o_rsp1_rdata    (rsp1_rdata),
        .o_mem_valid     (mem_valid),
        .i_mem_ready     (mem_ready),
        .o_mem_addr      (mem_addr),
        .o_mem_we        (mem_we),
        .o_mem_wdata     (mem_wdata),
        .i_mem_rsp_valid (mem_rsp_valid),
        .i_mem_rdata     (mem_rdata),
        .o_grant         (grant)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: who owns the port, and whether memory has
    // already taken the request. Round-robin uses the last completed owner.
    int m_owner  = -1;
    bit m_taken  = 0;
    bit m_grant  = 0;
    bit m_last   = 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_taken = 0;
            m_grant = 0;
            m_last  = 1;
        end else if (m_owner < 0) begin
            if (req0_valid || req1_valid) begin
                if (req0_valid && req1_valid) m_owner = m_last ? 0 : 1;
                else                          m_owner = req0_valid ? 0 : 1;
                m_grant = (m_owner == 1);
                m_taken = 0;
            end
        end else if (!m_taken) begin
            if (mem_ready) m_taken = 1;
        end else if (mem_rsp_valid) begin
            m_last  = (m_owner == 1);
            m_owner = -1;
        end
    end

    always @(negedge clk) begin
        bit e_issue;
        if (rst) begin
            check("rst_mem_valid", mem_valid, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_req_ready", {req1_ready, req0_ready}, 0);
            check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
            check("rst_grant", grant, 0);
        end else begin
            e_issue = (m_owner >= 0) && !m_taken;
            check("mem_valid", mem_valid, e_issue);
            check("grant", grant, m_grant);
            check("req0_ready", req0_ready, e_issue && m_owner == 0 && mem_ready);
            check("req1_ready", req1_ready, e_issue && m_owner == 1 && mem_ready);
            check("rsp0_valid", rsp0_valid, m_taken && m_owner == 0 && mem_rsp_valid);
            check("rsp1_valid", rsp1_valid, m_taken && m_owner == 1 && mem_rsp_valid);
            if (e_issue) begin
                check("mem_addr", mem_addr, (m_owner == 0) ? req0_addr : req1_addr);
                check("mem_we", mem_we, (m_owner == 0) ? req0_we : req1_we);
                check("mem_wdata", mem_wdata, (m_owner == 0) ? req0_wdata : req1_wdata);
            end
            if (rsp0_valid) check("rsp0_rdata", rsp0_rdata, mem_rdata);
            if (rsp1_valid) check("rsp1_rdata", rsp1_rdata, mem_rdata);
        end
        if (req0_ready) cnt_rdy0++;
        if (req1_ready) cnt_rdy1++;
        if (rsp0_valid) begin cnt_rsp0++; order_q.push_back(0); end
        if (rsp1_valid) begin cnt_rsp1++; order_q.push_back(1); end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        cnt_rdy0 = 0; cnt_rdy1 = 0; cnt_rsp0 = 0; cnt_rsp1 = 0;
        order_q.delete();
    endtask

    // Wait (bounded) for the request, accept it, then return a completion.
    task automatic serve(input logic [DW-1:0] rdata);
        for (int i = 0; i < 20 && !mem_valid; i++) step();
        check("serve_wait_mem_valid", mem_valid, 1);
        mem_ready = 1;
        step();
        mem_ready     = 0;
        mem_rsp_valid = 1;
        mem_rdata     = rdata;
        step();
        mem_rsp_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int exp_order[4];
        exp_order = '{0, 1, 0, 1};

        // reset
        step(); step();
        rst = 0;
        step();

        // port 0 read
        clear_counts();
        req0_valid = 1; req0_addr = 32'h0000_0040; req0_we = 0;
        step();
        mem_ready = 1;
        #1;
        check("p0_mem_addr", mem_addr, 32'h0000_0040);
        check("p0_req0_ready", req0_ready, 1);
        step();
        req0_valid = 0; mem_ready = 0;
        mem_rsp_valid = 1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("p0_rsp0_valid", rsp0_valid, 1);
        check("p0_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
        check("p0_rsp1_valid", rsp1_valid, 0);
        step();
        mem_rsp_valid = 0;
        step();
        check("p0_ready_pulses", cnt_rdy0, 1);
        check("p0_rsp1_pulses", cnt_rsp1, 0);

        // port 1 write
        clear_counts();
        req1_valid = 1; req1_addr = 32'h0000_1000; req1_we = 1; req1_wdata = 32'hCAFE_F00D;
        step();
        #1;
        check("p1_mem_we", mem_we, 1);
        check("p1_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        check("p1_mem_addr", mem_addr, 32'h0000_1000);
        mem_ready = 1;
        step();
        req1_valid = 0; mem_ready = 0;
        mem_rsp_valid = 1; mem_rdata = 32'h0;
        step();
        mem_rsp_valid = 0;
        step();
        check("p1_ready_pulses", cnt_rdy1, 1);
        check("p1_rsp_pulses", cnt_rsp1, 1);

        // memory stalls for 5 cycles in ISSUE
        clear_counts();
        req0_valid = 1; req0_addr = 32'h0000_0080; req0_we = 0; req0_wdata = 32'h1234_5678;
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_mem_valid", mem_valid, 1);
            check("stall_mem_addr", mem_addr, 32'h0000_0080);
            check("stall_req0_ready", req0_ready, 0);
            step();
        end
        mem_ready = 1;
        #1;
        check("stall_accept_valid", mem_valid, 1);
        check("stall_accept_ready", req0_ready, 1);
        step();
        req0_valid = 0; mem_ready = 0;
        mem_rsp_valid = 1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_rsp_valid = 0;
        step();
        check("stall_ready_pulses", cnt_rdy0, 1);

        // spurious completion in IDLE and in ISSUE
        mem_rsp_valid = 1;
        #1;
        check("spur_idle_rsp", {rsp1_valid, rsp0_valid}, 0);
        step();
        mem_rsp_valid = 0;
        check("spur_idle_mem_valid", mem_valid, 0);
        req1_valid = 1; req1_addr = 32'h0000_2000; req1_we = 0;
        step();
        mem_rsp_valid = 1;
        #1;
        check("spur_issue_rsp1", rsp1_valid, 0);
        step();
        mem_rsp_valid = 0;
        check("spur_issue_still_valid", mem_valid, 1);
        check("spur_issue_grant", grant, 1);
        mem_ready = 1;
        step();
        mem_ready = 0; req1_valid = 0;
        mem_rsp_valid = 1;
        step();
        mem_rsp_valid = 0;
        step();

        // reset in the middle of ISSUE, then a late completion
        clear_counts();
        req0_valid = 1; req0_addr = 32'h0000_0200; req0_we = 1; req0_wdata = 32'hFFFF_FFFF;
        step();
        #1 rst = 1;
        #1;
        check("midrst_mem_valid", mem_valid, 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wdata", mem_wdata, 0);
        check("midrst_grant", grant, 0);
        step();
        rst = 0; req0_valid = 0;
        mem_rsp_valid = 1; mem_rdata = 32'h5555_AAAA;
        #1;
        check("late_rsp0", rsp0_valid, 0);
        step();
        mem_rsp_valid = 0;
        step();
        check("late_rsp_pulses", cnt_rsp0 + cnt_rsp1, 0);

        // continuous contention from reset
        rst = 1;
        step();
        rst = 0;
        clear_counts();
        req0_valid = 1; req0_addr = 32'h0000_0300; req0_we = 0;
        req1_valid = 1; req1_addr = 32'h0000_0400; req1_we = 1; req1_wdata = 32'hA5A5_A5A5;
        for (int t = 0; t < 4; t++) serve(32'h100 + t);
        req0_valid = 0; req1_valid = 0;
        step();
        check("rr_count", order_q.size(), 4);
        for (int t = 0; t < 4 && t < order_q.size(); t++)
            check($sformatf("rr_order_%0d", t), order_q[t], exp_order[t]);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter2
